// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the debug-slave scan master.
package debug_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI,
        DONE
    } state_t;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    localparam int SR_WIDTH_DEF = 38;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// Test-clock divider: toggles vji_tck every TCK_DIV clk cycles while run is high.
// rise/fall flag the clk edge that will set tck to 1/0, so callers act on that same edge.
module debug_scan_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic vji_tck,
    output logic rise,
    output logic fall
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_tck;
    logic             w_wrap;

    assign w_wrap  = run && (r_div == DIV_LAST);
    assign rise    = w_wrap && !r_tck;
    assign fall    = w_wrap && r_tck;
    assign vji_tck = r_tck;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_tck <= !r_tck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/debug_scan_master.sv
// Host-side virtual-JTAG initiator: one command -> UIR, CDR, SDR x SR_WIDTH, UDR, RTI scan.
// Define DEBUG_SCAN_MASTER_IR_SKIP_EN to skip UIR when the IR matches the previous completed scan.
module debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int SR_WIDTH = SR_WIDTH_DEF,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int CNT_W = $clog2(SR_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SR_WIDTH - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [SR_WIDTH-1:0] r_shift;
    logic [SR_WIDTH-1:0] r_capture;
    logic [SR_WIDTH-1:0] r_rsp_data;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [1:0]          r_ir_in;
    logic [1:0]          r_rsp_ir_out;
    logic                w_run;
    logic                w_rise;
    logic                w_fall;
    logic                w_accept;
    logic                w_skip_uir;

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign w_run    = (r_state != IDLE) && (r_state != DONE);

    debug_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_run),
        .vji_tck (vji_tck),
        .rise    (w_rise),
        .fall    (w_fall)
    );

`ifdef DEBUG_SCAN_MASTER_IR_SKIP_EN
    logic r_ir_valid;

    // r_ir_in still holds the IR of the last completed scan while in IDLE.
    assign w_skip_uir = r_ir_valid && (cmd_ir == r_ir_in);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ir_valid <= 1'b0;
        end else if (r_state == RTI && w_fall) begin
            r_ir_valid <= 1'b1;
        end
    end
`else
    assign w_skip_uir = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_state_next = w_skip_uir ? CDR : UIR;
            UIR:  if (w_fall) w_state_next = CDR;
            CDR:  if (w_fall) w_state_next = SDR;
            SDR:  if (w_fall && r_bit_cnt == LAST_BIT) w_state_next = UDR;
            UDR:  if (w_fall) w_state_next = RTI;
            RTI:  if (w_fall) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shift      <= '0;
            r_capture    <= '0;
            r_rsp_data   <= '0;
            r_bit_cnt    <= '0;
            r_ir_in      <= '0;
            r_rsp_ir_out <= '0;
        end else begin
            if (w_accept) begin
                r_ir_in   <= cmd_ir;
                r_shift   <= cmd_data;
                r_bit_cnt <= '0;
            end
            if (r_state == UIR && w_rise) begin
                r_rsp_ir_out <= vji_ir_out;
            end
            // tdo is sampled on the edge that raises tck, before the slave shifts.
            if (r_state == SDR && w_rise) begin
                r_capture[r_bit_cnt] <= vji_tdo;
            end
            if (r_state == SDR && w_fall) begin
                r_shift   <= {1'b0, r_shift[SR_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == RTI && w_fall) begin
                r_rsp_data <= r_capture;
            end
        end
    end

    assign cmd_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == DONE);
    assign rsp_data   = r_rsp_data;
    assign rsp_ir_out = r_rsp_ir_out;
    assign vji_ir_in  = r_ir_in;
    assign vji_tdi    = (r_state == SDR) && r_shift[0];
    assign vji_uir    = (r_state == UIR);
    assign vji_cdr    = (r_state == CDR);
    assign vji_sdr    = (r_state == SDR);
    assign vji_udr    = (r_state == UDR);
    assign vji_rti    = (r_state == RTI);

endmodule

// File: tb/tb_debug_scan_master.sv
// Directed self-checking bench for debug_scan_master with a scoreboard of expected rsp_data.
// Latency is counted as clk edges from the accept edge to the edge that consumes rsp_valid.
module tb_debug_scan_master;
    import debug_scan_pkg::*;

    localparam int SRW       = 38;
    localparam int TDIV      = 2;
    localparam int PERIOD    = 2 * TDIV;
    localparam int BASE_LAT  = (SRW + 4) * PERIOD + 1;
    localparam int BASE_RISE = SRW + 4;
`ifdef DEBUG_SCAN_MASTER_IR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_ir;
    logic [SRW-1:0] cmd_data;
    logic           rsp_valid;
    logic [SRW-1:0] rsp_data;
    logic [1:0]     rsp_ir_out;
    logic           vji_tck, vji_tdi, vji_tdo;
    logic [1:0]     vji_ir_in;
    logic [1:0]     vji_ir_out;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    // Slave model: loopback, or a shift register shifting on tck rise (seen one clk later).
    logic           slave_mode = 1'b0;
    logic           slv_load = 1'b0;
    logic [SRW-1:0] slv_init = '0;
    logic [SRW-1:0] slv = '0;
    logic           tck_q = 1'b0;

    int             checks = 0;
    int             errors = 0;
    logic [SRW-1:0] exp_q[$];

    assign vji_tdo = slave_mode ? slv[0] : vji_tdi;

    always @(posedge clk) begin
        tck_q <= vji_tck;
        if (slv_load) begin
            slv <= slv_init;
        end else if (slave_mode && vji_sdr && vji_tck && !tck_q) begin
            slv <= {vji_tdi, slv[SRW-1:1]};
        end
    end

    always #5 clk = ~clk;

    debug_scan_master #(
        .SR_WIDTH (SRW),
        .TCK_DIV  (TDIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ir_out (rsp_ir_out),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_tdo    (vji_tdo),
        .vji_ir_in  (vji_ir_in),
        .vji_ir_out (vji_ir_out),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one command and pushes its expected response; returns after the accept edge.
    task automatic issue(input logic [1:0] ir, input logic [SRW-1:0] data, input logic [SRW-1:0] expd);
        @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = data;
        exp_q.push_back(expd);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_response(input string tag, input logic [1:0] ir, input int exp_lat,
                                 input int exp_uir, input int exp_rises, input logic [1:0] exp_irout);
        int             k = 0;
        int             uir = 0;
        int             rises = 0;
        int             ir_bad = 0;
        int             ready_bad = 0;
        logic           prev = 1'b0;
        logic           got = 1'b0;
        logic [SRW-1:0] expd;
        while (k < 4 * BASE_LAT) begin
            @(negedge clk);
            k++;
            if (vji_uir === 1'b1) uir++;
            if (vji_tck === 1'b1 && !prev) rises++;
            prev = vji_tck;
            if (vji_ir_in !== ir) ir_bad++;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (cmd_ready !== 1'b0) ready_bad++;
        end
        check({tag, "_resp_seen"}, got, 1);
        if (got) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
                expd = 'x;
            end else begin
                expd = exp_q.pop_front();
            end
            check({tag, "_data"}, rsp_data, expd);
            check({tag, "_latency"}, k, exp_lat);
            check({tag, "_uir_clk"}, uir, exp_uir);
            check({tag, "_tck_rises"}, rises, exp_rises);
            check({tag, "_ir_in_stable_bad"}, ir_bad, 0);
            check({tag, "_ready_busy_bad"}, ready_bad, 0);
            check({tag, "_ir_out"}, rsp_ir_out, exp_irout);
            @(negedge clk);
            check({tag, "_valid_pulse"}, rsp_valid, 0);
            check({tag, "_ready_after"}, cmd_ready, 1);
            check({tag, "_data_hold"}, rsp_data, expd);
        end
    endtask

    initial begin
        logic [63:0]    rnd;
        logic [SRW-1:0] d;
        logic [SRW-1:0] dv[3];
        logic [1:0]     last_irout;
        int             rises;
        int             acc;
        int             resp;
        int             ready_bad;
        int             stray;
        bit             busy;

        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ir     = 2'b00;
        cmd_data   = '0;
        vji_ir_out = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_outputs", {rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
        check("rst_rsp", {rsp_data, rsp_ir_out, vji_ir_in}, 0);
        reset_n = 1'b1;

        // Loopback, BREAK IR, alternating data pattern.
        vji_ir_out = 2'b01;
        issue(IR_BREAK, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A);
        wait_response("loop", IR_BREAK, BASE_LAT, PERIOD, BASE_RISE, 2'b01);

        // Slave register preloaded, zeros shifted in.
        @(negedge clk);
        slave_mode = 1'b1;
        slv_init   = 38'h3F_0000_0001;
        slv_load   = 1'b1;
        @(negedge clk);
        slv_load   = 1'b0;
        vji_ir_out = 2'b10;
        issue(IR_TRACEMEM, '0, 38'h3F_0000_0001);
        wait_response("slave", IR_TRACEMEM, BASE_LAT, PERIOD, BASE_RISE, 2'b10);
        check("slave_final", slv, 0);
        slave_mode = 1'b0;

        // ir_out capture with OCIMEM, random data in loopback.
        vji_ir_out = 2'b11;
        rnd = {$urandom(), $urandom()};
        d   = rnd[SRW-1:0];
        issue(IR_OCIMEM, d, d);
        wait_response("irout", IR_OCIMEM, BASE_LAT, PERIOD, BASE_RISE, 2'b11);

        // Reset during the 10th SDR bit (12th tck rise: UIR, CDR, then bits 0..9).
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = IR_TRACECTRL;
        cmd_data  = 38'h15_AAAA_5555;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rises = 0;
        for (int i = 0; i < 4 * BASE_LAT && rises < 12; i++) begin
            @(posedge clk);
            #1;
            if (vji_tck === 1'b1 && tck_q === 1'b0) rises++;
        end
        check("mid_rises_reached", rises, 12);
        @(negedge clk);
        check("mid_in_sdr", vji_sdr, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("mid_tck", vji_tck, 0);
        check("mid_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi}, 0);
        check("mid_ready", cmd_ready, 1);
        check("mid_rsp", {rsp_valid, rsp_data, rsp_ir_out, vji_ir_in}, 0);
        stray = 0;
        for (int i = 0; i < BASE_LAT + 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray++;
        end
        check("mid_no_rsp", stray, 0);
        vji_ir_out = 2'b01;
        rnd = {$urandom(), $urandom()};
        d   = rnd[SRW-1:0];
        issue(IR_TRACECTRL, d, d);
        wait_response("post_rst", IR_TRACECTRL, BASE_LAT, PERIOD, BASE_RISE, 2'b01);

        // cmd_valid held high across three back-to-back commands.
        vji_ir_out = 2'b10;
        dv[0] = 38'h01_2345_6789;
        dv[1] = 38'h3E_DCBA_9876;
        dv[2] = 38'h00_FFFF_0000;
        for (int i = 0; i < 3; i++) exp_q.push_back(dv[i]);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = IR_BREAK;
        cmd_data  = dv[0];
        acc = 0;
        resp = 0;
        ready_bad = 0;
        busy = 1'b0;
        for (int i = 0; i < 4 * 3 * BASE_LAT && resp < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL b2b_queue observed=empty expected=entry");
                end else begin
                    check("b2b_data", rsp_data, exp_q.pop_front());
                end
                resp++;
                busy = 1'b0;
                if (resp < 3) cmd_data = dv[resp];
                else cmd_valid = 1'b0;
            end else if (cmd_ready === 1'b1) begin
                if (busy) ready_bad++;
                else begin
                    acc++;
                    busy = 1'b1;
                end
            end
        end
        repeat (5) @(negedge clk);
        check("b2b_accepts", acc, 3);
        check("b2b_responses", resp, 3);
        check("b2b_ready_busy_bad", ready_bad, 0);
        check("b2b_idle_after", cmd_ready, 1);

        // Same IR twice, then a different IR.
        vji_ir_out = 2'b01;
        rnd = {$urandom(), $urandom()};
        d   = rnd[SRW-1:0];
        issue(IR_TRACEMEM, d, d);
        wait_response("skip_a", IR_TRACEMEM, BASE_LAT, PERIOD, BASE_RISE, 2'b01);
        last_irout = 2'b01;
        vji_ir_out = 2'b10;
        d = ~d;
        issue(IR_TRACEMEM, d, d);
        wait_response("skip_b", IR_TRACEMEM, SKIP ? BASE_LAT - PERIOD : BASE_LAT,
                      SKIP ? 0 : PERIOD, SKIP ? BASE_RISE - 1 : BASE_RISE,
                      SKIP ? last_irout : 2'b10);
        issue(IR_BREAK, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A);
        wait_response("skip_c", IR_BREAK, BASE_LAT, PERIOD, BASE_RISE, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
